bram_encode_write: RTL

- Write-back address encoder for the 8-BU NTT datapath, in the opposite direction to the read-side bank decoder.
- Captures the 8 core addresses and olen issued with each read beat, then delays them by the butterfly latency.
- Splits each A/B core address into bank index and bank row, then routes the 16 BU results through an 8x8 write crossbar to the A/B write ports of the 8 BRAM banks.
- Tracks in-flight beats and signals completion once the pipeline has drained.

---
 rtl/ntt_pkg.sv | 29 ++
 rtl/wr_crossbar_8x8.sv | 43 ++++
 rtl/bram_encode_write.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT write-back path: bank geometry,
// write-side FSM states and the core-address split into bank index and row.
package ntt_pkg;

  localparam int NUM_BANKS  = 8;
  localparam int BANK_IDX_W = 3;
  localparam int CORE_AW    = 8;
  localparam int ROW_W      = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } wr_state_e;

  typedef struct packed {
    logic [BANK_IDX_W-1:0] idx;
    logic [ROW_W-1:0]      row;
  } bank_addr_t;

  // Upper bits pick the bank, lower bits the row inside it.
  function automatic bank_addr_t split_core_addr(input logic [CORE_AW-1:0] addr);
    bank_addr_t r;
    r.idx = addr[CORE_AW-1 -: BANK_IDX_W];
    r.row = addr[ROW_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/wr_crossbar_8x8.sv
// One-port 8-lane to 8-bank write router. Lowest-numbered lane targeting a
// bank wins; any additional lane on the same bank raises conflict.
module wr_crossbar_8x8
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = 12
) (
  input  logic [NUM_BANKS*CORE_AW-1:0]    lane_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] lane_data,
  output logic [NUM_BANKS-1:0]            we,
  output logic [NUM_BANKS*ROW_W-1:0]      row,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] data,
  output logic                            conflict
);

  bank_addr_t dec;

  // Priority route every bank from the ascending lane scan.
  always_comb begin
    we       = '0;
    row      = '0;
    data     = '0;
    conflict = 1'b0;
    dec      = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int l = 0; l < NUM_BANKS; l++) begin
        dec = split_core_addr(lane_addr[l*CORE_AW +: CORE_AW]);
        if (dec.idx == BANK_IDX_W'(b)) begin
          if (we[b]) begin
            conflict = 1'b1;
          end else begin
            we[b]                           = 1'b1;
            row[b*ROW_W +: ROW_W]           = dec.row;
            data[b*DATA_WIDTH +: DATA_WIDTH] = lane_data[l*DATA_WIDTH +: DATA_WIDTH];
          end
        end else begin
          conflict = conflict;
        end
      end
    end
  end

endmodule

// File: rtl/bram_encode_write.sv
// Write-back address encoder: delays each read beat's addresses by the
// butterfly latency, then routes BU results to the 8 BRAM bank write ports.
module bram_encode_write
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int ADW        = 5,
  parameter int CAW        = 8,
  parameter int BU_LAT     = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            rd_valid_i,
  input  logic                            rd_done_i,
  input  logic [7:0]                      olen_i,
  input  logic [NUM_BANKS*CAW-1:0]        addr_core_i,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bu_a_i,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] bu_b_i,
  output logic [NUM_BANKS-1:0]            we_a_o,
  output logic [NUM_BANKS-1:0]            we_b_o,
  output logic [NUM_BANKS*ADW-1:0]        addr_a_o,
  output logic [NUM_BANKS*ADW-1:0]        addr_b_o,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] din_a_o,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] din_b_o,
  output logic                            busy_o,
  output logic                            conflict_o,
  output logic                            done_write_o
);

  localparam int CNT_W = $clog2(BU_LAT + 1);

  wr_state_e              state, state_next;
  logic [CNT_W-1:0]       drain_cnt, drain_cnt_next;
  logic                   capture, clear_conflict, done_next;

  logic [BU_LAT-1:0]          dl_valid, dl_valid_next;
  logic [NUM_BANKS*CAW-1:0]   dl_addr_a [BU_LAT];
  logic [NUM_BANKS*CAW-1:0]   dl_addr_b [BU_LAT];
  logic [NUM_BANKS*CAW-1:0]   addr_b_in;
  logic                       tail_valid;

  logic [NUM_BANKS-1:0]            xa_we, xb_we;
  logic [NUM_BANKS*ADW-1:0]        xa_row, xb_row;
  logic [NUM_BANKS*DATA_WIDTH-1:0] xa_data, xb_data;
  logic                            xa_conflict, xb_conflict;

  assign tail_valid = dl_valid[BU_LAT-1];

  // B partner address wraps modulo the core address space.
  always_comb begin
    addr_b_in = '0;
    for (int l = 0; l < NUM_BANKS; l++) begin
      addr_b_in[l*CAW +: CAW] = addr_core_i[l*CAW +: CAW] + CAW'(olen_i);
    end
  end

  always_comb begin
    dl_valid_next    = '0;
    dl_valid_next[0] = capture;
    for (int i = 1; i < BU_LAT; i++) begin
      dl_valid_next[i] = dl_valid[i-1];
    end
  end

  // The drain count includes the rd_done cycle, so done lands BU_LAT+1 cycles later.
  always_comb begin
    state_next     = state;
    drain_cnt_next = drain_cnt;
    capture        = 1'b0;
    clear_conflict = 1'b0;
    done_next      = 1'b0;
    case (state)
      IDLE: begin
        capture        = rd_valid_i;
        clear_conflict = rd_valid_i;
        if (rd_done_i) begin
          state_next     = DRAIN;
          drain_cnt_next = CNT_W'(BU_LAT);
        end else if (rd_valid_i) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        capture = rd_valid_i;
        if (rd_done_i) begin
          state_next     = DRAIN;
          drain_cnt_next = CNT_W'(BU_LAT);
        end else begin
          state_next = RUN;
        end
      end
      DRAIN: begin
        if (drain_cnt <= CNT_W'(1)) begin
          state_next     = IDLE;
          drain_cnt_next = '0;
          done_next      = 1'b1;
        end else begin
          drain_cnt_next = drain_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next     = IDLE;
        drain_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      drain_cnt <= '0;
      dl_valid  <= '0;
      for (int i = 0; i < BU_LAT; i++) begin
        dl_addr_a[i] <= '0;
        dl_addr_b[i] <= '0;
      end
    end else begin
      state        <= state_next;
      drain_cnt    <= drain_cnt_next;
      dl_valid     <= dl_valid_next;
      dl_addr_a[0] <= capture ? addr_core_i : '0;
      dl_addr_b[0] <= capture ? addr_b_in : '0;
      for (int i = 1; i < BU_LAT; i++) begin
        dl_addr_a[i] <= dl_addr_a[i-1];
        dl_addr_b[i] <= dl_addr_b[i-1];
      end
    end
  end

  wr_crossbar_8x8 #(.DATA_WIDTH(DATA_WIDTH)) u_xbar_a (
    .lane_addr (dl_addr_a[BU_LAT-1]),
    .lane_data (bu_a_i),
    .we        (xa_we),
    .row       (xa_row),
    .data      (xa_data),
    .conflict  (xa_conflict)
  );

  wr_crossbar_8x8 #(.DATA_WIDTH(DATA_WIDTH)) u_xbar_b (
    .lane_addr (dl_addr_b[BU_LAT-1]),
    .lane_data (bu_b_i),
    .we        (xb_we),
    .row       (xb_row),
    .data      (xb_data),
    .conflict  (xb_conflict)
  );

  // Registered write ports and status; idle ports drive zeros.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      we_a_o       <= '0;
      we_b_o       <= '0;
      addr_a_o     <= '0;
      addr_b_o     <= '0;
      din_a_o      <= '0;
      din_b_o      <= '0;
      busy_o       <= 1'b0;
      conflict_o   <= 1'b0;
      done_write_o <= 1'b0;
    end else begin
      we_a_o       <= tail_valid ? xa_we : '0;
      we_b_o       <= tail_valid ? xb_we : '0;
      addr_a_o     <= tail_valid ? xa_row : '0;
      addr_b_o     <= tail_valid ? xb_row : '0;
      din_a_o      <= tail_valid ? xa_data : '0;
      din_b_o      <= tail_valid ? xb_data : '0;
      busy_o       <= (state_next != IDLE) || (|dl_valid_next);
      conflict_o   <= clear_conflict ? 1'b0
                    : (conflict_o | (tail_valid & (xa_conflict | xb_conflict)));
      done_write_o <= done_next;
    end
  end

endmodule
